count_enable_gen: RTL and testbench

- Upstream stage of the eight-bit counter; drives the counter's enable input.
- Produces single-cycle enable pulses in one of two ways:
  - STEP mode: one pulse per debounced pushbutton press.
  - RUN mode: a periodic pulse from a programmable rate divider, which the pushbutton pauses and resumes.
- Shares the counter's clock and active-low clear, so the pair resets together.

---
 rtl/count_enable_pkg.sv | 15 +
 rtl/key_debouncer.sv | 58 +++++
 rtl/count_enable_gen.sv | 113 +++++++++++
 tb/tb_count_enable_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_enable_pkg.sv
// count_enable_pkg
// Shared definitions for the count-enable generator: FSM state encoding
// and the meaning of the mode input.
package count_enable_pkg;

    typedef enum logic [1:0] {
        S_STEP   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    localparam logic MODE_STEP = 1'b0;
    localparam logic MODE_RUN  = 1'b1;

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer
// Synchronizes a raw active-low pushbutton, debounces it and produces a
// one-cycle press strobe on each accepted press.
//
// Ports:
//   clock     - rising-edge clock
//   clear     - synchronous active-low reset
//   key_n     - raw asynchronous pushbutton, 0 = pressed
//   key_level - debounced key state, 1 = pressed
//   press     - one-cycle strobe in the cycle after key_level rises
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_WIDTH        = 20
) (
    input  logic clock,
    input  logic clear,
    input  logic key_n,
    output logic key_level,
    output logic press
);

    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

    // The synchronizer carries the raw key_n level, so its idle value is 1.
    logic [1:0]          sync_q;
    logic                s;
    logic [DB_WIDTH-1:0] count_q;
    logic                key_level_q;
    logic                key_level_d_q;

    assign s = ~sync_q[1];

    always_ff @(posedge clock) begin
        if (!clear) begin
            sync_q        <= 2'b11;
            count_q       <= '0;
            key_level_q   <= 1'b0;
            key_level_d_q <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], key_n};
            key_level_d_q <= key_level_q;
            // Any sample agreeing with the accepted level restarts the run,
            // so only an unbroken run of DEBOUNCE_CYCLES samples is accepted.
            if (s == key_level_q) begin
                count_q <= '0;
            end else if (count_q == DB_LAST) begin
                key_level_q <= s;
                count_q     <= '0;
            end else begin
                count_q <= count_q + DB_WIDTH'(1);
            end
        end
    end

    assign key_level = key_level_q;
    assign press     = key_level_q & ~key_level_d_q;

endmodule

// File: rtl/count_enable_gen.sv
// count_enable_gen
// Drives the enable input of the eight-bit counter. In STEP mode each
// debounced key press yields one enable pulse; in RUN mode a programmable
// divider yields a pulse every rate+1 cycles and key presses pause/resume it.
//
// Ports:
//   clock     - rising-edge clock, shared with the counter
//   clear     - synchronous active-low reset, shared with the counter
//   key_n     - raw asynchronous pushbutton, 0 = pressed
//   mode      - 0 = STEP, 1 = RUN (quasi-static)
//   rate      - RUN-mode period minus 1, sampled at each divider reload
//   enable    - registered one-cycle pulse to the counter
//   key_level - debounced key state, 1 = pressed
//   paused    - high while RUN mode is paused
module count_enable_gen
    import count_enable_pkg::*;
#(
    parameter int DIV_WIDTH       = 26,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_WIDTH        = 20
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 key_n,
    input  logic                 mode,
    input  logic [DIV_WIDTH-1:0] rate,
    output logic                 enable,
    output logic                 key_level,
    output logic                 paused
);

    logic                 press;
    state_t               state_q;
    state_t               state_d;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_d;
    logic                 enable_q;
    logic                 enable_d;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_WIDTH       (DB_WIDTH)
    ) u_key_debouncer (
        .clock    (clock),
        .clear    (clear),
        .key_n    (key_n),
        .key_level(key_level),
        .press    (press)
    );

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q  <= S_STEP;
            div_q    <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            enable_q <= enable_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        enable_d = 1'b0;
        if (mode == MODE_STEP) begin
            // Leaving RUN/PAUSED emits nothing; only an in-STEP press pulses.
            state_d = S_STEP;
            if (state_q == S_STEP) begin
                enable_d = press;
            end
        end else begin
            case (state_q)
                S_STEP: begin
                    if (mode == MODE_RUN) begin
                        state_d = S_RUN;
                        div_d   = rate;
                    end
                end
                S_RUN: begin
                    // A press landing on a terminal count still emits that
                    // pulse; the pause applies from the next cycle.
                    if (div_q == '0) begin
                        enable_d = 1'b1;
                        div_d    = rate;
                    end else begin
                        div_d = div_q - DIV_WIDTH'(1);
                    end
                    if (press) begin
                        state_d = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (press) begin
                        state_d = S_RUN;
                        div_d   = rate;
                    end
                end
                default: begin
                    state_d = S_STEP;
                end
            endcase
        end
    end

    always_comb begin
        paused = (state_q == S_PAUSED);
    end

    assign enable = enable_q;

endmodule

// File: tb/tb_count_enable_gen.sv
module tb_count_enable_gen;

    logic       clock = 1'b0;
    logic       clear;
    logic       key_n;
    logic       mode;
    logic [7:0] rate;
    logic       enable;
    logic       key_level;
    logic       paused;

    int total = 0;
    int bad   = 0;

    count_enable_gen #(
        .DIV_WIDTH      (8),
        .DEBOUNCE_CYCLES(4),
        .DB_WIDTH       (3)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .key_n    (key_n),
        .mode     (mode),
        .rate     (rate),
        .enable   (enable),
        .key_level(key_level),
        .paused   (paused)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       clear;
        logic       key_n;
        logic       mode;
        logic [7:0] rate;
        logic       en;
        logic       kl;
        logic       ps;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic c, input logic k, input logic m,
                       input logic e, input logic l, input logic p, input int n);
        vec_t v;
        v.clear = c; v.key_n = k; v.mode = m; v.rate = 8'd0;
        v.en = e; v.kl = l; v.ps = p;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int pulses;
        logic found;

        clear = 1'b0; key_n = 1'b0; mode = 1'b1; rate = 8'd0;

        // Reset with key held, then key re-debounced; clean release after.
        add(0, 0, 1, 0, 0, 0, 3);
        add(1, 0, 0, 0, 0, 0, 5);
        add(1, 0, 0, 0, 1, 0, 1);
        add(1, 0, 0, 1, 1, 0, 1);
        add(1, 0, 0, 0, 1, 0, 5);
        add(1, 1, 0, 0, 1, 0, 5);
        add(1, 1, 0, 0, 0, 0, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            clear = vecs[i].clear;
            key_n = vecs[i].key_n;
            mode  = vecs[i].mode;
            rate  = vecs[i].rate;
            tick();
            check($sformatf("vec%0d_enable", i), enable, vecs[i].en);
            check($sformatf("vec%0d_key_level", i), key_level, vecs[i].kl);
            check($sformatf("vec%0d_paused", i), paused, vecs[i].ps);
        end

        // Bounce: 2-cycle low/high toggling must never be accepted.
        for (int i = 0; i < 20; i++) begin
            key_n = (i < 12) ? logic'((i / 2) % 2) : 1'b1;
            tick();
            check("bounce_key_level", key_level, 1'b0);
            check("bounce_enable", enable, 1'b0);
        end

        // RUN with rate=3: first pulse 4 cycles in, 5 pulses in 20 cycles.
        rate = 8'd3; mode = 1'b1;
        tick();
        check("run_entry_enable", enable, 1'b0);
        first = 0; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (enable) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        check_int("run_rate3_first", first, 4);
        check_int("run_rate3_count", pulses, 5);

        // rate=0 takes effect at the next reload, then enable stays high.
        rate = 8'd0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (enable) found = 1'b1;
        end
        check("run_rate0_reload", found, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("run_rate0_enable", enable, 1'b1);
        end

        // Press coincident with divider==0: pulse kept, pause next cycle.
        key_n = 1'b0;
        repeat (6) tick();
        check("pause_key_level", key_level, 1'b1);
        tick();
        check("coincident_enable", enable, 1'b1);
        check("coincident_paused", paused, 1'b1);
        tick();
        check("paused_enable", enable, 1'b0);
        check("paused_paused", paused, 1'b1);
        rate = 8'd5; key_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("paused_release_enable", enable, 1'b0);
            check("paused_release_paused", paused, 1'b1);
        end
        check("paused_release_level", key_level, 1'b0);

        // Resume: divider reloads with rate=5, next pulse 6 cycles later.
        key_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("resume_wait_enable", enable, 1'b0);
        end
        tick();
        check("resume_paused", paused, 1'b0);
        check("resume_enable", enable, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("resume_enable_c%0d", i), enable, (i == 6));
        end

        // Pause in RUN at rate=5 away from terminal count: no pulse.
        key_n = 1'b1;
        repeat (8) tick();
        check("rerelease_level", key_level, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (enable) found = 1'b1;
        end
        check("rate5_pulse_seen", found, 1'b1);
        key_n = 1'b0;
        repeat (6) tick();
        tick();
        check("pause2_paused", paused, 1'b1);
        check("pause2_enable", enable, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pause2_hold_enable", enable, 1'b0);
        end

        // Mode drop while paused and key held: STEP, no pulse.
        mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("modedrop_paused", paused, 1'b0);
            check("modedrop_enable", enable, 1'b0);
        end

        // Clear mid-debounce restarts the count.
        key_n = 1'b1;
        repeat (8) tick();
        check("pre_clear_level", key_level, 1'b0);
        key_n = 1'b0;
        repeat (4) tick();
        clear = 1'b0;
        tick();
        check("midclear_level", key_level, 1'b0);
        check("midclear_enable", enable, 1'b0);
        check("midclear_paused", paused, 1'b0);
        clear = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("postclear_level_c%0d", i), key_level, (i >= 6));
            check($sformatf("postclear_enable_c%0d", i), enable, (i == 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
